// File: rtl/rgb888_to_565_serializer_if.sv
`default_nettype none
// ------------------------------------------------------------------
// rgb888_to_565_serializer_if : pixel-in / byte-out stream bundle
// Revision: 1.0
// ------------------------------------------------------------------
interface rgb888_to_565_serializer_if;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_r8;
  logic [7:0] s_g8;
  logic [7:0] s_b8;
  logic       s_sof;
  logic       s_eol;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_sof;
  logic       m_eol;

  modport master (
    output s_valid, s_r8, s_g8, s_b8, s_sof, s_eol, m_ready,
    input  s_ready, m_valid, m_data, m_sof, m_eol
  );

  modport slave (
    input  s_valid, s_r8, s_g8, s_b8, s_sof, s_eol, m_ready,
    output s_ready, m_valid, m_data, m_sof, m_eol
  );
endinterface
`default_nettype wire

// File: rtl/rgb888_to_565_serializer.sv
`default_nettype none
// ------------------------------------------------------------------
// rgb888_to_565_serializer : RGB888 -> RGB565, high byte first, with line-length check
// Optional macro RGB_ROUND_EN: round-to-nearest with saturation. Revision: 1.0
// ------------------------------------------------------------------
module rgb888_to_565_serializer #(
  parameter int H_ACTIVE = 320,
  parameter int CNT_W    = 10
) (
  input  logic                       pclk,
  input  logic                       rstn,
  rgb888_to_565_serializer_if.slave  bus,
  output logic [CNT_W-1:0]           pix_cnt,
  output logic                       len_err
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HI    = 2'd1,
    LO    = 2'd2
  } state_t;

  state_t           state;
  logic             out_valid;
  logic [7:0]       out_data;
  logic             out_sof;
  logic             out_eol;
  logic [7:0]       lo_byte;
  logic             eol_tag;
  logic [15:0]      px_in;
  logic             accept;
  logic [CNT_W-1:0] cnt_next;
  logic             at_limit;
  logic             err_set;

`ifdef RGB_ROUND_EN
  function automatic logic [4:0] round5(input logic [7:0] v);
    logic [8:0] sum;
    sum = {1'b0, v} + 9'd4;
    return sum[8] ? 5'd31 : sum[7:3];
  endfunction

  function automatic logic [5:0] round6(input logic [7:0] v);
    logic [8:0] sum;
    sum = {1'b0, v} + 9'd2;
    return sum[8] ? 6'd63 : sum[7:2];
  endfunction

  assign px_in = {round5(bus.s_r8), round6(bus.s_g8), round5(bus.s_b8)};
`else
  assign px_in = {bus.s_r8[7:3], bus.s_g8[7:2], bus.s_b8[7:3]};
`endif

  assign bus.s_ready = rstn && (state == EMPTY || (state == LO && bus.m_ready));
  assign accept      = bus.s_valid && bus.s_ready;

  assign bus.m_valid = out_valid;
  assign bus.m_data  = out_data;
  assign bus.m_sof   = out_sof;
  assign bus.m_eol   = out_eol;

  // A start-of-frame pixel restarts the count, so it always counts as 1.
  assign cnt_next = (bus.s_sof ? '0 : pix_cnt) + CNT_W'(1);
  assign at_limit = (cnt_next == CNT_W'(H_ACTIVE));
  assign err_set  = bus.s_eol ? !at_limit : at_limit;

  always_ff @(posedge pclk) begin
    if (!rstn) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      lo_byte   <= '0;
      eol_tag   <= 1'b0;
      pix_cnt   <= '0;
      len_err   <= 1'b0;
    end else if (accept) begin
      state     <= HI;
      out_valid <= 1'b1;
      out_data  <= px_in[15:8];
      out_sof   <= bus.s_sof;
      out_eol   <= 1'b0;
      lo_byte   <= px_in[7:0];
      eol_tag   <= bus.s_eol;
      pix_cnt   <= bus.s_eol ? '0 : cnt_next;
      len_err   <= err_set | (len_err & ~bus.s_sof);
    end else if (bus.m_ready) begin
      case (state)
        HI: begin
          state    <= LO;
          out_data <= lo_byte;
          out_sof  <= 1'b0;
          out_eol  <= eol_tag;
        end
        LO: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          out_data  <= '0;
          out_eol   <= 1'b0;
        end
        default: begin
          state <= EMPTY;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/rgb888_to_565_serializer.md
# rgb888_to_565_serializer

Converts 24-bit RGB888 pixels to RGB565 and emits each pixel as two bytes, high byte first, on an 8-bit valid/ready stream. It sits on the Zybo side output path, ahead of any DVP-style byte link or 16-bit frame-buffer writer that expects the camera's native 565 byte order. It tracks the line length and flags lines that do not match the configured active width.

## Interface
- H_ACTIVE, 320, number of active pixels per line; used for the line-length check.
- CNT_W, 10, width of `pix_cnt`; must satisfy 2^CNT_W > H_ACTIVE.

- pclk  in  1  pixel clock; all logic is on its rising edge.
- rstn  in  1  reset, synchronous and active-low.
- s_valid  in  1  input pixel valid.
- s_ready  out  1  input pixel accepted when `s_valid && s_ready`.
- s_r8, s_g8, s_b8  in  8 each  input colour components.
- s_sof  in  1  input pixel is the first pixel of a frame.
- s_eol  in  1  input pixel is the last pixel of a line.
- m_valid  out  1  output byte valid.
- m_ready  in  1  output byte consumed when `m_valid && m_ready`.
- m_data  out  8  output byte.
- m_sof  out  1  qualifies the high byte of a frame's first pixel.
- m_eol  out  1  qualifies the low byte of a line's last pixel.
- pix_cnt  out  CNT_W  number of pixels accepted in the current line.
- len_err  out  1  sticky line-length error.

## Operation
- The block has one 16-bit pixel holding register plus `sof`/`eol` tags. The FSM has three states: EMPTY, HI, LO.
- `m_valid = (state != EMPTY)`.
- `s_ready = rstn && (state == EMPTY || (state == LO && m_ready))`.
- **On accept:**
  - The converted pixel and its tags are loaded into the register.
  - The FSM moves to HI.
- **In HI:**
  - `m_data` = px[15:8] and `m_sof` = sof tag; `m_eol` = 0.
  - When `m_ready` is high, the FSM moves to LO.
- **In LO:**
  - `m_data` = px[7:0] and `m_eol` = eol tag; `m_sof` = 0.
  - When `m_ready` is high: if `s_valid` is high, the next pixel is accepted and the FSM moves to HI; otherwise it moves to EMPTY.
- **Conversion (default):** truncation.
  - r5 = r8[7:3], g6 = g8[7:2], b5 = b8[7:3].
  - px = {r5, g6, b5}.
- **Line counter:**
  - Each accepted pixel increments `pix_cnt`.
  - An accepted pixel with `s_sof` first resets `pix_cnt` to 0 before counting itself, so it counts as 1.
  - An accepted pixel with `s_sof` also clears `len_err`, unless that same pixel sets it.
  - An accepted pixel with `s_eol` sets `len_err` if its count ≠ H_ACTIVE, then sets `pix_cnt` to 0.
  - An accepted pixel without `s_eol` whose count equals H_ACTIVE sets `len_err`; counting continues.
  - `pix_cnt` wraps modulo 2^CNT_W.
- **Simultaneous sof and eol on one pixel:** the counter is reset, counts 1 and is checked; with H_ACTIVE ≠ 1 this sets `len_err`.

## Timing
- **Reset values:** state EMPTY, `m_valid` 0, `m_data` 0x00, `m_sof` 0, `m_eol` 0, `pix_cnt` 0, `len_err` 0, `s_ready` 0 while `rstn` is low.
- **Latency:** a pixel accepted on edge N presents its high byte from edge N (valid in cycle N+1) and its low byte one handshake later.
- **Throughput:** with `m_ready` held high, one byte per cycle, i.e. one pixel every 2 cycles. `s_ready` is high only in cycles where the LO byte is consumed, or when the FSM is EMPTY.
- `m_data` and the tags hold stable while `m_valid && !m_ready`.
- **Reset mid-pixel:** a pending byte is dropped and never completed. The first pixel after reset starts with its HI byte.

## Configuration
- `RGB_ROUND_EN` selects round-to-nearest conversion with saturation instead of truncation.
  - **Defined:** r5 = min((r8+4)>>3, 31), g6 = min((g8+2)>>2, 63), b5 = min((b8+4)>>3, 31).
  - **Undefined:** truncation as in Operation.
- Latency and handshake are identical in both builds. The rounding result is registered at the same point as the truncated value.

## Test plan
- **Single pixel, truncation:**
  - Stimulus: (0x84, 0x82, 0x84) with `m_ready`=1 and `RGB_ROUND_EN` undefined.
  - Response: bytes 0x84 then 0x10.
  - With `RGB_ROUND_EN` defined, the same pixel gives 0x8C then 0x31.
- **Saturation (`RGB_ROUND_EN` defined):**
  - Stimulus: (0xFE, 0xFF, 0xFE).
  - Response: bytes 0xFF, 0xFF; no wrap to 0.
- **Backpressure:**
  - Stimulus: `m_ready`=0 for 5 cycles while in HI.
  - Response: `m_data`, `m_sof` and `m_valid` stay constant, and `s_ready` stays 0. Release `m_ready` and the LO byte follows.
- **Full line stream:**
  - Stimulus: continuous `s_valid`, `m_ready`=1, 320 pixels with `s_sof` on the first and `s_eol` on the last.
  - Response: 640 bytes on consecutive cycles; `m_sof` only on byte 1 and `m_eol` only on byte 640; `len_err`=0; `pix_cnt` returns to 0.
- **Short line:**
  - Stimulus: `s_eol` on pixel 319.
  - Response: `len_err`=1, held through later lines, and cleared by the next accepted `s_sof` pixel.
- **Reset in LO:**
  - Stimulus: assert `rstn`=0 for 1 cycle while in LO.
  - Response: `m_valid`=0 on the following cycle and the LO byte is never emitted. The next pixel emits its HI byte first, with `pix_cnt` counting from 1.
